tx_link_scheduler: RTL and testbench

//  Sequences the 8b/10b serial transmitter: runs PRBS link training after reset or on request,

---
 rtl/tx_link_scheduler.sv | 158 +++++++++++++++
 tb/tb_tx_link_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: runs PRBS link training on the 8b/10b transmitter, then arbitrates
// control bytes and packetised data bytes into the transmitter through one holding register.
module tx_link_scheduler #(
   parameter int TRAIN_CYCLES = 1024,
   parameter int CNT_W        = 16
) (
   input  logic             clk_bit,
   input  logic             rst_n,
   input  logic [7:0]       ctrl_data,
   input  logic             ctrl_valid,
   output logic             ctrl_pop,
   input  logic [7:0]       data_data,
   input  logic             data_valid,
   input  logic             data_last,
   output logic             data_pop,
   input  logic             retrain,
   output logic [7:0]       tx_d_in,
   output logic             tx_d_in_valid,
   output logic             tx_prbs_on,
   input  logic             tx_read_enable,
   input  logic             tx_idle,
   output logic             training,
   output logic [CNT_W-1:0] ctrl_sent,
   output logic [CNT_W-1:0] data_sent
);

   typedef enum logic {ST_TRAIN, ST_RUN} state_t;
   typedef enum logic {SRC_CTRL, SRC_DATA} src_t;

   localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] train_cnt_q, train_cnt_d;
   logic [7:0]       hold_data_q, hold_data_d;
   logic             hold_valid_q, hold_valid_d;
   src_t             hold_src_q, hold_src_d;
   src_t             last_grant_q, last_grant_d;
   logic             pkt_lock_q, pkt_lock_d;
   logic             retrain_pend_q, retrain_pend_d;
   logic             ctrl_pop_d, data_pop_d;
   logic [CNT_W-1:0] ctrl_sent_d, data_sent_d;
   logic             can_pick, grant_ctrl, grant_data, enter_train;

   // The transmitter's idle indication carries no scheduling information.
   logic unused_tx_idle;
   assign unused_tx_idle = tx_idle;

   assign tx_d_in       = hold_data_q;
   assign tx_d_in_valid = hold_valid_q;
   assign training      = tx_prbs_on;

   // NOTE: every signal gets its default first so no path through this block can infer a latch.
   always_comb begin
      state_d        = state_q;
      train_cnt_d    = train_cnt_q;
      hold_data_d    = hold_data_q;
      hold_valid_d   = hold_valid_q;
      hold_src_d     = hold_src_q;
      last_grant_d   = last_grant_q;
      pkt_lock_d     = pkt_lock_q;
      retrain_pend_d = retrain_pend_q | retrain;
      ctrl_pop_d     = 1'b0;
      data_pop_d     = 1'b0;
      ctrl_sent_d    = ctrl_sent;
      data_sent_d    = data_sent;
      grant_ctrl     = 1'b0;
      grant_data     = 1'b0;
      enter_train    = 1'b0;

      // A pop issued last cycle must reach the source before the next pick.
      can_pick = (state_q == ST_RUN) && !hold_valid_q && !ctrl_pop && !data_pop;

      if (state_q == ST_TRAIN) begin
         if (train_cnt_q == TRAIN_LAST) begin
            state_d     = ST_RUN;
            train_cnt_d = '0;
         end else begin
            train_cnt_d = train_cnt_q + CNT_ONE;
         end
      end else if (can_pick) begin
         if (pkt_lock_q) begin
            grant_data = data_valid;
         end else if (retrain_pend_q) begin
            enter_train = 1'b1;
         end else if (ctrl_valid && data_valid) begin
            grant_ctrl = (last_grant_q == SRC_DATA);
            grant_data = (last_grant_q == SRC_CTRL);
         end else begin
            grant_ctrl = ctrl_valid;
            grant_data = data_valid;
         end
      end

      if (enter_train) begin
         state_d        = ST_TRAIN;
         train_cnt_d    = '0;
         retrain_pend_d = retrain;
      end

      if (hold_valid_q && tx_read_enable) begin
         hold_valid_d = 1'b0;
         if (hold_src_q == SRC_CTRL) ctrl_sent_d = ctrl_sent + CNT_ONE;
         else                        data_sent_d = data_sent + CNT_ONE;
      end

      if (grant_ctrl) begin
         hold_data_d  = ctrl_data;
         hold_valid_d = 1'b1;
         hold_src_d   = SRC_CTRL;
         last_grant_d = SRC_CTRL;
         ctrl_pop_d   = 1'b1;
      end

      if (grant_data) begin
         hold_data_d  = data_data;
         hold_valid_d = 1'b1;
         hold_src_d   = SRC_DATA;
         last_grant_d = SRC_DATA;
         pkt_lock_d   = !data_last;
         data_pop_d   = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_bit or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_TRAIN;
         train_cnt_q    <= '0;
         hold_data_q    <= '0;
         hold_valid_q   <= 1'b0;
         hold_src_q     <= SRC_CTRL;
         last_grant_q   <= SRC_DATA;
         pkt_lock_q     <= 1'b0;
         retrain_pend_q <= 1'b0;
         ctrl_pop       <= 1'b0;
         data_pop       <= 1'b0;
         tx_prbs_on     <= 1'b1;
         ctrl_sent      <= '0;
         data_sent      <= '0;
      end else begin
         state_q        <= state_d;
         train_cnt_q    <= train_cnt_d;
         hold_data_q    <= hold_data_d;
         hold_valid_q   <= hold_valid_d;
         hold_src_q     <= hold_src_d;
         last_grant_q   <= last_grant_d;
         pkt_lock_q     <= pkt_lock_d;
         retrain_pend_q <= retrain_pend_d;
         ctrl_pop       <= ctrl_pop_d;
         data_pop       <= data_pop_d;
         tx_prbs_on     <= (state_d == ST_TRAIN);
         ctrl_sent      <= ctrl_sent_d;
         data_sent      <= data_sent_d;
      end
   end

endmodule

// File: tb/tb_tx_link_scheduler.sv
// tb_tx_link_scheduler: source and transmitter models around tx_link_scheduler; accepted bytes
// are compared against a queue of expected bytes filled when each scenario is set up.
module tb_tx_link_scheduler;

   localparam int TRAIN_CYCLES = 16;
   localparam int CNT_W        = 16;
   localparam int SLOT         = 10;

   typedef struct packed { logic is_data; logic [7:0] value; } exp_t;
   typedef struct packed { logic last; logic [7:0] value; } dbyte_t;

   logic             clk_bit = 1'b0;
   logic             rst_n;
   logic [7:0]       ctrl_data;
   logic             ctrl_valid;
   logic             ctrl_pop;
   logic [7:0]       data_data;
   logic             data_valid;
   logic             data_last;
   logic             data_pop;
   logic             retrain;
   logic [7:0]       tx_d_in;
   logic             tx_d_in_valid;
   logic             tx_prbs_on;
   logic             tx_read_enable;
   logic             tx_idle;
   logic             training;
   logic [CNT_W-1:0] ctrl_sent;
   logic [CNT_W-1:0] data_sent;

   tx_link_scheduler #(.TRAIN_CYCLES(TRAIN_CYCLES), .CNT_W(CNT_W)) dut (
      .clk_bit        (clk_bit),
      .rst_n          (rst_n),
      .ctrl_data      (ctrl_data),
      .ctrl_valid     (ctrl_valid),
      .ctrl_pop       (ctrl_pop),
      .data_data      (data_data),
      .data_valid     (data_valid),
      .data_last      (data_last),
      .data_pop       (data_pop),
      .retrain        (retrain),
      .tx_d_in        (tx_d_in),
      .tx_d_in_valid  (tx_d_in_valid),
      .tx_prbs_on     (tx_prbs_on),
      .tx_read_enable (tx_read_enable),
      .tx_idle        (tx_idle),
      .training       (training),
      .ctrl_sent      (ctrl_sent),
      .data_sent      (data_sent)
   );

   always #5 clk_bit = ~clk_bit;

   logic [7:0]       ctrl_src[$];
   dbyte_t           data_src[$];
   exp_t             exp_q[$];
   logic             ctrl_gate, data_gate, tx_en, cnt_check_pend, prev_valid;
   logic [CNT_W-1:0] exp_ctrl, exp_data;
   int               slot_cnt;
   int               n_ctrl_pop, n_data_pop, n_double, n_pop_in_train, n_valid_rise;
   int               n_tests = 0;
   int               n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Byte sources and transmitter model; everything changes 1 time unit after the clock edge.
   initial begin
      ctrl_gate = 1'b1; data_gate = 1'b1; tx_en = 1'b0; cnt_check_pend = 1'b0;
      prev_valid = 1'b0; exp_ctrl = '0; exp_data = '0; slot_cnt = 0;
      n_ctrl_pop = 0; n_data_pop = 0; n_double = 0; n_pop_in_train = 0; n_valid_rise = 0;
      ctrl_data = 8'h00; ctrl_valid = 1'b0; data_data = 8'h00; data_valid = 1'b0;
      data_last = 1'b0; tx_read_enable = 1'b0; tx_idle = 1'b0;
      forever begin
         @(posedge clk_bit);
         #1;
         tx_read_enable = 1'b0;
         tx_idle        = 1'b0;
         if (cnt_check_pend) begin
            cnt_check_pend = 1'b0;
            check("ctrl_sent_step", 32'(ctrl_sent), 32'(exp_ctrl));
            check("data_sent_step", 32'(data_sent), 32'(exp_data));
         end
         if (ctrl_pop && data_pop) n_double++;
         if ((ctrl_pop || data_pop) && tx_prbs_on) n_pop_in_train++;
         if (ctrl_pop) begin
            n_ctrl_pop++;
            if (ctrl_src.size() > 0) void'(ctrl_src.pop_front());
         end
         if (data_pop) begin
            n_data_pop++;
            if (data_src.size() > 0) void'(data_src.pop_front());
         end
         if (tx_d_in_valid && !prev_valid) n_valid_rise++;
         prev_valid = tx_d_in_valid;

         ctrl_valid = ctrl_gate && (ctrl_src.size() > 0);
         ctrl_data  = (ctrl_src.size() > 0) ? ctrl_src[0] : 8'h00;
         data_valid = data_gate && (data_src.size() > 0);
         data_data  = (data_src.size() > 0) ? data_src[0].value : 8'h00;
         data_last  = (data_src.size() > 0) ? data_src[0].last : 1'b0;

         if (tx_en) begin
            if (slot_cnt == SLOT - 1) begin
               slot_cnt       = 0;
               tx_read_enable = 1'b1;
               tx_idle        = !tx_d_in_valid;
               if (tx_d_in_valid) begin
                  if (exp_q.size() == 0) begin
                     check("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
                  end else begin
                     exp_t e;
                     e = exp_q.pop_front();
                     check("tx_byte", 32'(tx_d_in), 32'(e.value));
                     if (e.is_data) exp_data = exp_data + 1'b1;
                     else           exp_ctrl = exp_ctrl + 1'b1;
                     cnt_check_pend = 1'b1;
                  end
               end
            end else begin
               slot_cnt++;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_bit);
         #2;
      end
   endtask

   task automatic push_ctrl(input logic [7:0] v);
      exp_t e;
      ctrl_src.push_back(v);
      e.is_data = 1'b0; e.value = v;
      exp_q.push_back(e);
   endtask

   task automatic push_data(input logic [7:0] v, input logic last);
      dbyte_t d;
      exp_t   e;
      d.last = last; d.value = v;
      data_src.push_back(d);
      e.is_data = 1'b1; e.value = v;
      exp_q.push_back(e);
   endtask

   task automatic wait_data_pop(input string tag, input int base);
      for (int k = 0; k < 200 && n_data_pop == base; k++) tick(1);
      check(tag, 32'(n_data_pop > base), 32'd1);
   endtask

   // Waits until every expected byte was accepted; counts PRBS samples seen while waiting.
   task automatic wait_drain(input string tag, input int budget, input bit settle,
                             output int prbs_seen);
      prbs_seen = 0;
      for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
         tick(1);
         if (tx_prbs_on) prbs_seen++;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
      if (settle) tick(4);
   endtask

   // Counts clock periods (sampled on falling edges) with tx_prbs_on high.
   task automatic measure_train(input string tag);
      int hi;
      hi = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk_bit);
         if (tx_prbs_on) begin
            hi++;
            if (hi == 1) check({tag, "_training_hi"}, 32'(training), 32'd1);
         end else if (hi > 0) begin
            break;
         end
      end
      check(tag, 32'(hi), 32'(TRAIN_CYCLES));
      check({tag, "_training_lo"}, 32'(training), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_tx_d_in"},    32'(tx_d_in), 32'd0);
      check({tag, "_valid"},      32'(tx_d_in_valid), 32'd0);
      check({tag, "_prbs"},       32'(tx_prbs_on), 32'd1);
      check({tag, "_training"},   32'(training), 32'd1);
      check({tag, "_ctrl_pop"},   32'(ctrl_pop), 32'd0);
      check({tag, "_data_pop"},   32'(data_pop), 32'd0);
      check({tag, "_ctrl_sent"},  32'(ctrl_sent), 32'd0);
      check({tag, "_data_sent"},  32'(data_sent), 32'd0);
   endtask

   initial begin
      int prbs_seen;
      int base;
      rst_n   = 1'b0;
      retrain = 1'b0;

      // Reset, training length, then two control bytes.
      tick(1);
      push_ctrl(8'hA1);
      push_ctrl(8'hA2);
      tx_en = 1'b1;
      tick(3);
      check_reset_values("reset");
      rst_n = 1'b1;
      measure_train("t1_train_len");
      check("t1_ctrl_sent_after_train", 32'(ctrl_sent), 32'd0);
      wait_drain("t2_drain", 300, 1'b1, prbs_seen);
      check("t2_ctrl_sent", 32'(ctrl_sent), 32'd2);
      check("t2_ctrl_pops", 32'(n_ctrl_pop), 32'd2);
      check("t2_valid_periods", 32'(n_valid_rise), 32'd2);
      check("t2_data_sent", 32'(data_sent), 32'd0);

      // Control raised inside a 4-byte packet must wait for the last byte.
      ctrl_gate = 1'b0;
      ctrl_src.push_back(8'hC4);
      push_data(8'h10, 1'b0);
      push_data(8'h11, 1'b0);
      push_data(8'h12, 1'b0);
      push_data(8'h13, 1'b1);
      begin
         exp_t e;
         e.is_data = 1'b0; e.value = 8'hC4;
         exp_q.push_back(e);
      end
      wait_data_pop("t4_first_pop", n_data_pop);
      ctrl_gate = 1'b1;
      wait_drain("t4_drain", 600, 1'b1, prbs_seen);
      check("t4_data_sent", 32'(data_sent), 32'd4);
      check("t4_ctrl_sent", 32'(ctrl_sent), 32'd3);

      // Data stalls mid-packet: transmitter idles, control stays blocked.
      push_data(8'h20, 1'b0);
      push_data(8'h21, 1'b0);
      push_data(8'h22, 1'b1);
      push_ctrl(8'hC5);
      wait_data_pop("t5_first_pop", n_data_pop);
      data_gate = 1'b0;
      base = n_ctrl_pop;
      tick(30);
      check("t5_no_ctrl_grant", 32'(n_ctrl_pop - base), 32'd0);
      check("t5_idle_valid", 32'(tx_d_in_valid), 32'd0);
      data_gate = 1'b1;
      wait_drain("t5_drain", 600, 1'b1, prbs_seen);
      check("t5_data_sent", 32'(data_sent), 32'd7);
      check("t5_ctrl_sent", 32'(ctrl_sent), 32'd4);

      // Retrain requested mid-packet is deferred until the packet has gone.
      push_data(8'h30, 1'b0);
      push_data(8'h31, 1'b0);
      push_data(8'h32, 1'b1);
      wait_data_pop("t6_first_pop", n_data_pop);
      retrain = 1'b1;
      tick(1);
      retrain = 1'b0;
      wait_drain("t6_drain", 600, 1'b0, prbs_seen);
      check("t6_prbs_before_last", 32'(prbs_seen), 32'd0);
      measure_train("t6_retrain_len");
      check("t6_data_sent", 32'(data_sent), 32'd10);

      // Reset in the middle of a packet.
      tx_en = 1'b0;
      tick(2);
      push_data(8'h40, 1'b0);
      push_data(8'h41, 1'b0);
      push_data(8'h42, 1'b1);
      wait_data_pop("t6r_first_pop", n_data_pop);
      tick(2);
      @(negedge clk_bit);
      rst_n = 1'b0;
      #1;
      check_reset_values("t6r_midpkt");
      ctrl_src.delete();
      data_src.delete();
      exp_q.delete();
      exp_ctrl = '0;
      exp_data = '0;
      cnt_check_pend = 1'b0;

      // Both sources always valid after reset: C,D,C,D...
      for (int i = 0; i < 4; i++) begin
         push_ctrl(8'hB0 + 8'(i));
         push_data(8'h50 + 8'(i), 1'b1);
      end
      tx_en = 1'b1;
      tick(3);
      rst_n = 1'b1;
      measure_train("t3_train_len");
      wait_drain("t3_drain", 800, 1'b1, prbs_seen);
      check("t3_ctrl_sent", 32'(ctrl_sent), 32'd4);
      check("t3_data_sent", 32'(data_sent), 32'd4);

      check("no_double_pop", 32'(n_double), 32'd0);
      check("no_pop_in_train", 32'(n_pop_in_train), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
